uart_tx_engine: RTL



---
 rtl/uart_tx_engine.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from a show-ahead TX FIFO and shifts them
// out LSB-first with a start bit, optional parity and 1 or 2 stop bits.
module uart_tx_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_enable,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
  input  logic                      parity_en,
  input  logic                      parity_odd,
  input  logic                      stop2,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_req,
  output logic                      uart_txd,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]            LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [BAUD_DIV_WIDTH-1:0] DIV_ONE  = BAUD_DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                    r_state;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_parity_bit;
  logic                      r_parity_en;
  logic                      r_stop2;
  logic [BAUD_DIV_WIDTH-1:0] r_div;
  logic [BAUD_DIV_WIDTH-1:0] r_cnt;
  logic [BCW-1:0]            r_bit_cnt;
  logic                      r_stop_cnt;
  logic                      r_txd;
  logic                      r_done;

  logic [BAUD_DIV_WIDTH-1:0] w_div_eff;
  logic [DATA_WIDTH-1:0]     w_shift_nxt;
  logic                      w_pop;
  logic                      w_bit_end;

  assign w_div_eff   = (baud_div == '0) ? DIV_ONE : baud_div;
  assign w_shift_nxt = r_shift >> 1;
  assign w_bit_end   = (r_cnt == '0);
  // Pop is combinational so the pop cycle itself counts as busy.
  assign w_pop       = (r_state == S_IDLE) && tx_enable && !fifo_empty && !reset;

  assign fifo_rd_req = w_pop;
  assign uart_txd    = r_txd;
  assign tx_busy     = (r_state != S_IDLE) || w_pop;
  assign tx_done     = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_parity_bit <= 1'b0;
      r_parity_en  <= 1'b0;
      r_stop2      <= 1'b0;
      r_div        <= '0;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_txd        <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift      <= fifo_rd_data;
            r_parity_bit <= (^fifo_rd_data) ^ parity_odd;
            r_parity_en  <= parity_en;
            r_stop2      <= stop2;
            r_div        <= w_div_eff;
            r_cnt        <= w_div_eff - DIV_ONE;
            r_txd        <= 1'b0;
            r_state      <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt     <= r_div - DIV_ONE;
            r_bit_cnt <= '0;
            r_txd     <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= r_div - DIV_ONE;
            if (r_bit_cnt == LAST_BIT) begin
              r_stop_cnt <= 1'b0;
              if (r_parity_en) begin
                r_txd   <= r_parity_bit;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_shift   <= w_shift_nxt;
              r_txd     <= w_shift_nxt[0];
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= r_div - DIV_ONE;
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_stop_cnt == r_stop2) begin
              r_done    <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_stop_cnt <= 1'b1;
              r_cnt      <= r_div - DIV_ONE;
            end
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
